pwm_duty_ctrl: RTL and testbench
================================

PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 SHALL expose parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples before a button level is accepted.
REQ-002 SHALL expose parameter DUTY_RESET, default 5: duty step after reset (5 = 50%).
REQ-003 SHALL expose parameter MAX_STEP, default 10: top duty step (10 = 100%, 10% per step).
REQ-004 SHALL have port clk, input, 1, single system clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port ena, input, 1, block enable.
REQ-007 SHALL have port ui_increase_duty, input, 1, raw asynchronous increase button.
REQ-008 SHALL have port ui_decrease_duty, input, 1, raw asynchronous decrease button.
REQ-009 SHALL have port period_end, input, 1, one-cycle pulse from the PWM counter on its last count of a period.
REQ-010 SHALL have port duty_step, output, 4, current committed duty step, 0..MAX_STEP.
REQ-011 SHALL have port duty_update, output, 1, one-cycle pulse in the cycle duty_step changes.
REQ-012 SHALL have ports at_max and at_min, output, 1 each, combinational flags duty_step==MAX_STEP and duty_step==0.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer, then a debouncer accepting a new level after DEBOUNCE_CYCLES identical synchronized samples.
REQ-014 SHALL generate one press event on each debounced 0->1 transition; holding a button produces no further events (unless REQ-027 applies).
REQ-015 SHALL hold a pending request in a 3-state FSM: NONE, PEND_INC, PEND_DEC.
REQ-016 SHALL transition NONE->PEND_INC on inc event and NONE->PEND_DEC on dec event.
REQ-017 SHALL treat an opposite-direction event while pending as cancel (->NONE); a same-direction event while pending is dropped (no accumulation).
REQ-018 SHALL treat inc and dec events in the same cycle as cancelling each other: FSM state unchanged.
REQ-019 SHALL commit a pending request only in a cycle with period_end=1: duty_step +/-1 on the next edge, duty_update=1 that same next cycle, FSM ->NONE.
REQ-020 SHALL saturate: PEND_INC at MAX_STEP or PEND_DEC at 0 returns to NONE on period_end with no change and no duty_update pulse.
REQ-021 SHALL process an event arriving in the same cycle as period_end as pending for the next period_end, not the current one.
REQ-022 SHALL, while ena=0, ignore button events, force FSM to NONE, hold duty_step, keep duty_update=0; debouncers keep tracking.
REQ-023 SHALL keep duty_step within 0..MAX_STEP at all times; no wrap-around.

Reset
REQ-024 SHALL on rst_n=0, immediately and asynchronously: duty_step=DUTY_RESET, duty_update=0, FSM=NONE, debounced levels=0, debounce counters=0, synchronizers=0.
REQ-025 SHALL, when reset asserts mid-operation, discard any pending request; first release cycle behaves as fresh power-up.
REQ-026 SHALL not generate a press event on reset release even if a button is held high (debounced level starts at 0 and must count DEBOUNCE_CYCLES).

Configuration
REQ-027 SHALL, with macro PWM_DUTY_CTRL_AUTOREPEAT_EN defined, generate repeat events for a debounced-high button after HOLD_CYCLES=64 and then every REPEAT_CYCLES=16 while held, each treated as a press event.
REQ-028 SHALL, without PWM_DUTY_CTRL_AUTOREPEAT_EN, contain no repeat counters; one event per press only.

Structure
REQ-029 SHALL place the FSM state enum, step width (4) and default HOLD_CYCLES/REPEAT_CYCLES constants in shared package pwm_pkg.
REQ-030 SHALL implement synchronizer+debouncer+edge detect as sub-module pwm_btn_debounce, instantiated twice.

Verification
REQ-031 Reset with buttons low -> duty_step=5, at_min=at_max=0, duty_update=0.
REQ-032 Inc pressed 10 cycles, period_end every 100 cycles -> duty_step 5->6 one cycle after next period_end, single duty_update pulse.
REQ-033 Glitch of 2 cycles on ui_increase_duty -> no event, duty_step unchanged after 3 period_ends.
REQ-034 From duty_step=10, inc press then period_end -> duty_step stays 10, no duty_update, at_max=1; from 0 with dec -> stays 0, at_min=1.
REQ-035 Inc and dec debounced same cycle, or inc then dec before period_end -> no change at next period_end.
REQ-036 Pending inc, rst_n pulsed low mid-period -> duty_step=5 immediately, no update after release at period_end.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-step controller.
package pwm_pkg;
  localparam int STEP_W        = 4;
  localparam int HOLD_CYCLES   = 64;
  localparam int REPEAT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_PEND_INC,
    ST_PEND_DEC
  } req_state_t;
endpackage

// File: rtl/pwm_btn_debounce.sv
// Button conditioner: 2-flop sync, level debouncer, one-cycle press pulse on debounced rise.
// With PWM_DUTY_CTRL_AUTOREPEAT_EN, a held button also emits repeat pulses.
module pwm_btn_debounce
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronized input disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  logic press_edge;
  assign press_edge = level & ~level_q;

`ifdef PWM_DUTY_CTRL_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_fire;

  // After the first hold interval the counter reloads so later repeats come every REPEAT_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt <= '0;
    end else if (!level) begin
      rpt_cnt <= '0;
    end else if (rpt_cnt == RPT_LAST) begin
      rpt_cnt <= RPT_RELOAD;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  assign rpt_fire = level && (rpt_cnt == RPT_LAST);
  assign press    = press_edge | rpt_fire;
`else
  assign press = press_edge;
`endif
endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty-step controller: debounced inc/dec requests are held pending and committed on period_end.
// Optional auto-repeat of held buttons via PWM_DUTY_CTRL_AUTOREPEAT_EN.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DUTY_RESET      = 5,
  parameter int MAX_STEP        = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              ui_increase_duty,
  input  logic              ui_decrease_duty,
  input  logic              period_end,
  output logic [STEP_W-1:0] duty_step,
  output logic              duty_update,
  output logic              at_max,
  output logic              at_min
);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEP);
  localparam logic [STEP_W-1:0] STEP_RST = STEP_W'(DUTY_RESET);

  logic inc_press;
  logic dec_press;

  pwm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (ui_increase_duty),
    .press (inc_press)
  );

  pwm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (ui_decrease_duty),
    .press (dec_press)
  );

  req_state_t state;
  req_state_t state_nxt;
  logic       do_inc;
  logic       do_dec;
  logic       inc_only;
  logic       dec_only;

  assign at_max   = (duty_step == STEP_MAX);
  assign at_min   = (duty_step == '0);
  assign inc_only = inc_press & ~dec_press;
  assign dec_only = dec_press & ~inc_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_NONE;
    end else begin
      state <= state_nxt;
    end
  end

  // On period_end the pending request is resolved first; a same-cycle event pends for the next period.
  always_comb begin
    state_nxt = state;
    do_inc    = 1'b0;
    do_dec    = 1'b0;
    if (!ena) begin
      state_nxt = ST_NONE;
    end else if (period_end) begin
      do_inc = (state == ST_PEND_INC) && !at_max;
      do_dec = (state == ST_PEND_DEC) && !at_min;
      if (inc_only) begin
        state_nxt = ST_PEND_INC;
      end else if (dec_only) begin
        state_nxt = ST_PEND_DEC;
      end else begin
        state_nxt = ST_NONE;
      end
    end else begin
      case (state)
        ST_NONE: begin
          if (inc_only) begin
            state_nxt = ST_PEND_INC;
          end else if (dec_only) begin
            state_nxt = ST_PEND_DEC;
          end
        end
        ST_PEND_INC: if (dec_only) state_nxt = ST_NONE;
        ST_PEND_DEC: if (inc_only) state_nxt = ST_NONE;
        default:     state_nxt = ST_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_step   <= STEP_RST;
      duty_update <= 1'b0;
    end else begin
      duty_update <= do_inc | do_dec;
      if (do_inc) begin
        duty_step <= duty_step + 1'b1;
      end else if (do_dec) begin
        duty_step <= duty_step - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed self-checking bench for pwm_duty_ctrl (default build, DEBOUNCE_CYCLES=4).
module tb_pwm_duty_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       ui_increase_duty = 1'b0;
  logic       ui_decrease_duty = 1'b0;
  logic       period_end = 1'b0;
  logic [3:0] duty_step;
  logic       duty_update;
  logic       at_max;
  logic       at_min;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  pwm_duty_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ena              (ena),
    .ui_increase_duty (ui_increase_duty),
    .ui_decrease_duty (ui_decrease_duty),
    .period_end       (period_end),
    .duty_step        (duty_step),
    .duty_update      (duty_update),
    .at_max           (at_max),
    .at_min           (at_min)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (duty_update === 1'b1) upd_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_inc();
    ui_increase_duty = 1'b1;
    tick(10);
    ui_increase_duty = 1'b0;
    tick(10);
  endtask

  task automatic press_dec();
    ui_decrease_duty = 1'b1;
    tick(10);
    ui_decrease_duty = 1'b0;
    tick(10);
  endtask

  task automatic pend();
    period_end = 1'b1;
    tick(1);
    period_end = 1'b0;
  endtask

  initial begin
    // Reset state, sampled while reset is still asserted.
    tick(3);
    check("rst_step", duty_step, 5);
    check("rst_at_min", at_min, 0);
    check("rst_at_max", at_max, 0);
    check("rst_update", duty_update, 0);
    rst_n = 1'b1;
    tick(2);

    // Basic increment: no change until period_end, then one pulse.
    press_inc();
    tick(70);
    check("inc_before_pe", duty_step, 5);
    check("inc_no_early_upd", upd_cnt, 0);
    pend();
    check("inc_step", duty_step, 6);
    check("inc_update", duty_update, 1);
    tick(1);
    check("inc_update_clear", duty_update, 0);
    check("inc_single_pulse", upd_cnt, 1);
    tick(20);
    pend();
    check("inc_no_repeat", duty_step, 6);

    // Two-cycle glitch is filtered.
    ui_increase_duty = 1'b1;
    tick(2);
    ui_increase_duty = 1'b0;
    tick(10);
    for (int i = 0; i < 3; i++) begin
      pend();
      tick(20);
    end
    check("glitch_step", duty_step, 6);
    check("glitch_upd", upd_cnt, 1);

    // Simultaneous inc/dec cancel.
    ui_increase_duty = 1'b1;
    ui_decrease_duty = 1'b1;
    tick(10);
    ui_increase_duty = 1'b0;
    ui_decrease_duty = 1'b0;
    tick(10);
    pend();
    check("both_cancel", duty_step, 6);

    // inc then dec before period_end cancels.
    press_inc();
    press_dec();
    pend();
    check("inc_dec_cancel", duty_step, 6);
    check("cancel_no_upd", duty_update, 0);

    // Plain decrement.
    press_dec();
    pend();
    check("dec_step", duty_step, 5);
    check("dec_update", duty_update, 1);

    // Event landing on the period_end cycle waits for the next one.
    ui_increase_duty = 1'b1;
    tick(6);
    period_end = 1'b1;
    tick(1);
    period_end = 1'b0;
    check("same_cycle_hold", duty_step, 5);
    check("same_cycle_no_upd", duty_update, 0);
    ui_increase_duty = 1'b0;
    tick(12);
    pend();
    check("same_cycle_next", duty_step, 6);

    // Climb to the top and saturate.
    for (int i = 0; i < 4; i++) begin
      press_inc();
      pend();
    end
    check("max_step", duty_step, 10);
    check("max_flag", at_max, 1);
    tick(1);
    press_inc();
    pend();
    check("sat_max_step", duty_step, 10);
    check("sat_max_no_upd", duty_update, 0);
    check("sat_max_flag", at_max, 1);
    press_dec();
    pend();
    check("sat_max_returned_none", duty_step, 9);

    // Descend to the bottom and saturate.
    for (int i = 0; i < 9; i++) begin
      press_dec();
      pend();
    end
    check("min_step", duty_step, 0);
    check("min_flag", at_min, 1);
    tick(1);
    press_dec();
    pend();
    check("sat_min_step", duty_step, 0);
    check("sat_min_no_upd", duty_update, 0);
    check("sat_min_flag", at_min, 1);

    // Disabled block ignores presses and drops pending requests.
    ena = 1'b0;
    press_inc();
    pend();
    check("ena0_step", duty_step, 0);
    check("ena0_no_upd", duty_update, 0);
    ena = 1'b1;
    press_inc();
    ena = 1'b0;
    tick(2);
    ena = 1'b1;
    tick(2);
    pend();
    check("ena0_flush", duty_step, 0);

    // Reset mid-period discards pending request.
    press_inc();
    rst_n = 1'b0;
    #1;
    check("rst_async_step", duty_step, 5);
    check("rst_async_upd", duty_update, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    pend();
    check("rst_no_commit", duty_step, 5);
    check("rst_no_upd", duty_update, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
